decode_top: RTL and testbench

- Decode stage sitting directly upstream of the ALU stage.
- Accepts one 32-bit instruction per cycle from fetch and reads operands from an internal 32-entry register file; it also owns that register file.
- Tracks pending destination writes with a scoreboard and stalls fetch on RAW hazards.
- Presents registered opcode, operands, destination and PC to the ALU. The register file is written by the writeback port.

---
 rtl/decode_top_pkg.sv | 33 +++
 rtl/decode_top_regfile_2r1w.sv | 28 ++
 rtl/decode_top.sv | 100 ++++++++++
 tb/tb_decode_top.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_top_pkg.sv
// decode_top_pkg: opcodes, instruction field positions and opcode classification shared by the decode stage
package decode_top_pkg;
  localparam int REG_AW = 5;
  localparam int OPC_W = 8;
  localparam int OPC_HI = 31, OPC_LO = 24;
  localparam int RD_HI = 23, RD_LO = 19;
  localparam int RA_HI = 18, RA_LO = 14;
  localparam int RB_HI = 13, RB_LO = 9;
  localparam int OFF_HI = 13, OFF_LO = 0;
  localparam int OFF_W = OFF_HI - OFF_LO + 1;
  localparam logic [OPC_W-1:0] OP_ADD = 8'h00, OP_SUB = 8'h01, OP_MUL = 8'h02;
  localparam logic [OPC_W-1:0] OP_LDB = 8'h10, OP_LDW = 8'h11, OP_STB = 8'h12, OP_STW = 8'h13;
  localparam logic [OPC_W-1:0] OP_BEQ = 8'h30, OP_JUMP = 8'h31, OP_TLBWRITE = 8'h32, OP_IRET = 8'h33;
  typedef struct packed {
    logic wr;
    logic use_a;
    logic use_b;
    logic rb_op;
  } dec_t;
  function automatic dec_t classify(input logic [OPC_W-1:0] op);
    dec_t d;
    d = '0;
    case (op)
      OP_ADD, OP_SUB, OP_MUL:   d = '{1'b1, 1'b1, 1'b1, 1'b1};
      OP_LDB, OP_LDW:           d = '{1'b1, 1'b1, 1'b0, 1'b0};
      OP_STB, OP_STW, OP_BEQ:   d = '{1'b0, 1'b1, 1'b1, 1'b0};
      OP_JUMP:                  d = '{1'b0, 1'b1, 1'b0, 1'b0};
      OP_TLBWRITE:              d = '{1'b0, 1'b1, 1'b1, 1'b1};
      default:                  d = '0;
    endcase
    return d;
  endfunction
endpackage

// File: rtl/decode_top_regfile_2r1w.sv
// decode_top_regfile_2r1w: register file, two combinational read ports, one write port, r0 hardwired to zero
//   clock/reset_c : clock, async active-low reset (clears all entries)
//   we/wa/wd      : write strobe, address, data
//   ra_a/q_a      : read port A address/data
//   ra_b/q_b      : read port B address/data
module decode_top_regfile_2r1w
  import decode_top_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int REG_W = 32
) (
  input  logic              clock,
  input  logic              reset_c,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [REG_W-1:0]  wd,
  input  logic [REG_AW-1:0] ra_a,
  output logic [REG_W-1:0]  q_a,
  input  logic [REG_AW-1:0] ra_b,
  output logic [REG_W-1:0]  q_b
);
  logic [REG_W-1:0] mem [NUM_REGS];
  always_ff @(posedge clock or negedge reset_c)
    if (!reset_c) for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    else if (we && wa != '0) mem[wa] <= wd;
  assign q_a = (ra_a == '0) ? '0 : mem[ra_a];
  assign q_b = (ra_b == '0) ? '0 : mem[ra_b];
endmodule

// File: rtl/decode_top.sv
// decode_top: decode stage with register file, RAW scoreboard and registered ALU-facing output
//   clock/reset_c                     : clock, async active-low reset
//   fetch_valid/fetch_instr/fetch_pc  : instruction from fetch; decode_stall tells fetch to hold it
//   stall_alu/flush                   : ALU backpressure and taken-branch kill of the output register
//   wb_valid/wb_rd/wb_data            : register-file writeback, also clears the scoreboard entry
//   dec_valid/instr/val1/val2/store_data/rdIn/pc_out : registered decoded instruction
//   WB_BYPASS_EN                      : when defined, a same-cycle writeback feeds the operand directly
module decode_top
  import decode_top_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int REG_W = 32,
  parameter int PC_W = 32
) (
  input  logic              clock,
  input  logic              reset_c,
  input  logic              fetch_valid,
  input  logic [31:0]       fetch_instr,
  input  logic [PC_W-1:0]   fetch_pc,
  output logic              decode_stall,
  input  logic              stall_alu,
  input  logic              flush,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [REG_W-1:0]  wb_data,
  output logic              dec_valid,
  output logic [OPC_W-1:0]  instr,
  output logic [REG_W-1:0]  val1,
  output logic [REG_W-1:0]  val2,
  output logic [REG_W-1:0]  store_data,
  output logic [REG_AW-1:0] rdIn,
  output logic [PC_W-1:0]   pc_out
);
  logic [OPC_W-1:0] op;
  logic [REG_AW-1:0] rd, ra, rb;
  logic [REG_W-1:0] rf_a, rf_b, a_val, b_val, off_ext;
  logic [NUM_REGS-1:0] busy, busy_n;
  logic haz_a, haz_b, hazard, issue;
  dec_t d;
  assign op = fetch_instr[OPC_HI:OPC_LO];
  assign rd = fetch_instr[RD_HI:RD_LO];
  assign ra = fetch_instr[RA_HI:RA_LO];
  assign rb = fetch_instr[RB_HI:RB_LO];
  assign off_ext = {{(REG_W-OFF_W){fetch_instr[OFF_HI]}}, fetch_instr[OFF_HI:OFF_LO]};
  assign d = classify(op);
  decode_top_regfile_2r1w #(.NUM_REGS(NUM_REGS), .REG_W(REG_W)) u_rf (
    .clock(clock), .reset_c(reset_c),
    .we(wb_valid), .wa(wb_rd), .wd(wb_data),
    .ra_a(ra), .q_a(rf_a), .ra_b(rb), .q_b(rf_b)
  );
`ifdef WB_BYPASS_EN
  logic hit_a, hit_b;
  assign hit_a = wb_valid && wb_rd == ra && ra != '0;
  assign hit_b = wb_valid && wb_rd == rb && rb != '0;
  assign a_val = hit_a ? wb_data : rf_a;
  assign b_val = hit_b ? wb_data : rf_b;
  assign haz_a = d.use_a && busy[ra] && !hit_a;
  assign haz_b = d.use_b && busy[rb] && !hit_b;
`else
  // without bypass the read sees the old value, so a source written back this cycle must wait one more cycle
  assign a_val = rf_a;
  assign b_val = rf_b;
  assign haz_a = d.use_a && busy[ra];
  assign haz_b = d.use_b && busy[rb];
`endif
  assign hazard = fetch_valid && (haz_a || haz_b);
  assign decode_stall = hazard || flush || (stall_alu && dec_valid);
  assign issue = fetch_valid && !decode_stall;
  // set is applied last so a same-cycle issue of rd beats the writeback clear
  always_comb begin
    busy_n = busy;
    if (wb_valid) busy_n[wb_rd] = 1'b0;
    if (flush && dec_valid) busy_n[rdIn] = 1'b0;
    if (issue && d.wr && rd != '0) busy_n[rd] = 1'b1;
  end
  // rdIn is zero for non-writing instructions, which makes the flush clear of busy[rdIn] harmless for them
  always_ff @(posedge clock or negedge reset_c)
    if (!reset_c) begin
      busy <= '0;
      dec_valid <= 1'b0;
      instr <= '0;
      val1 <= '0;
      val2 <= '0;
      store_data <= '0;
      rdIn <= '0;
      pc_out <= '0;
    end else begin
      busy <= busy_n;
      if (flush) dec_valid <= 1'b0;
      else if (issue) begin
        dec_valid <= 1'b1;
        instr <= op;
        val1 <= a_val;
        val2 <= d.rb_op ? b_val : off_ext;
        store_data <= b_val;
        rdIn <= d.wr ? rd : '0;
        pc_out <= fetch_pc;
      end else if (!stall_alu) dec_valid <= 1'b0;
    end
endmodule

// File: tb/tb_decode_top.sv
// tb_decode_top: directed scenarios plus randomized traffic against a behavioural model of the decode stage
module tb_decode_top;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clock = 1'b0, reset_c = 1'b0;
  logic fetch_valid = 1'b0, stall_alu = 1'b0, flush = 1'b0, wb_valid = 1'b0;
  logic [31:0] fetch_instr = '0, fetch_pc = '0, wb_data = '0;
  logic [4:0] wb_rd = '0;
  logic decode_stall, dec_valid;
  logic [7:0] instr;
  logic [31:0] val1, val2, store_data, pc_out;
  logic [4:0] rdIn;
  int vecs = 0, errs = 0;

  decode_top dut (
    .clock(clock), .reset_c(reset_c), .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .fetch_pc(fetch_pc), .decode_stall(decode_stall), .stall_alu(stall_alu), .flush(flush),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .dec_valid(dec_valid), .instr(instr),
    .val1(val1), .val2(val2), .store_data(store_data), .rdIn(rdIn), .pc_out(pc_out)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb);
    return {op, rd, ra, rb, 9'd0};
  endfunction
  function automatic logic [31:0] mk_off(input logic [7:0] op, input logic [4:0] rd, input logic [4:0] ra, input logic [13:0] off);
    return {op, rd, ra, off};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic idle();
    fetch_valid = 1'b0; stall_alu = 1'b0; flush = 1'b0; wb_valid = 1'b0;
  endtask
  task automatic do_reset();
    idle();
    reset_c = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_c = 1'b1;
    #1;
  endtask
  task automatic wb(input logic [4:0] r, input logic [31:0] v);
    wb_valid = 1'b1; wb_rd = r; wb_data = v;
    tick();
    wb_valid = 1'b0;
  endtask
  task automatic issue_one(input logic [31:0] ins, input logic [31:0] pc);
    fetch_valid = 1'b1; fetch_instr = ins; fetch_pc = pc;
    tick();
    fetch_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vecs++;
    if ({dec_valid, instr, val1, val2, store_data, rdIn, pc_out} !== '0) begin
      errs++; $display("FAIL reset_outputs got v=%b i=%h %h %h %h rd=%h pc=%h want all 0", dec_valid, instr, val1, val2, store_data, rdIn, pc_out);
    end
    fetch_valid = 1'b1; fetch_instr = mk(8'h00, 5'd3, 5'd1, 5'd2); #1;
    vecs++;
    if (decode_stall !== 1'b0) begin errs++; $display("FAIL reset_no_stall got %b want 0", decode_stall); end
    fetch_valid = 1'b0;
  endtask

  task automatic test_basic_add();
    do_reset();
    wb(5'd1, 32'd5);
    wb(5'd2, 32'd7);
    issue_one(mk(8'h00, 5'd3, 5'd1, 5'd2), 32'h100);
    vecs++;
    if ({dec_valid, instr, val1, val2, rdIn, pc_out} !== {1'b1, 8'h00, 32'd5, 32'd7, 5'd3, 32'h100}) begin
      errs++; $display("FAIL add got v=%b op=%h %h %h rd=%0d pc=%h want 1 00 5 7 3 100", dec_valid, instr, val1, val2, rdIn, pc_out);
    end
  endtask

  task automatic test_raw_hazard();
    fetch_valid = 1'b1; fetch_instr = mk(8'h01, 5'd4, 5'd3, 5'd1); fetch_pc = 32'h104;
    for (int i = 0; i < 2; i++) begin
      #1;
      vecs++;
      if (decode_stall !== 1'b1) begin errs++; $display("FAIL raw_stall%0d got %b want 1", i, decode_stall); end
      tick();
    end
    vecs++;
    if (dec_valid !== 1'b0) begin errs++; $display("FAIL raw_bubble got %b want 0", dec_valid); end
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'd12; #1;
    vecs++;
    if (decode_stall !== !BYP) begin errs++; $display("FAIL raw_wb_cycle_stall got %b want %b", decode_stall, !BYP); end
    tick();
    wb_valid = 1'b0;
`ifndef WB_BYPASS_EN
    #1;
    vecs++;
    if (decode_stall !== 1'b0) begin errs++; $display("FAIL raw_after_wb_stall got %b want 0", decode_stall); end
    tick();
`endif
    fetch_valid = 1'b0;
    vecs++;
    if ({dec_valid, instr, val1, val2, rdIn} !== {1'b1, 8'h01, 32'd12, 32'd5, 5'd4}) begin
      errs++; $display("FAIL raw_sub got v=%b op=%h %h %h rd=%0d want 1 01 c 5 4", dec_valid, instr, val1, val2, rdIn);
    end
  endtask

  task automatic test_load_offset();
    do_reset();
    wb(5'd1, 32'h100);
    issue_one(mk_off(8'h11, 5'd5, 5'd1, 14'h3FFC), 32'h200);
    vecs++;
    if ({dec_valid, instr, val1, val2, rdIn} !== {1'b1, 8'h11, 32'h100, 32'hFFFFFFFC, 5'd5}) begin
      errs++; $display("FAIL ldw got v=%b op=%h %h %h rd=%0d want 1 11 100 fffffffc 5", dec_valid, instr, val1, val2, rdIn);
    end
    fetch_valid = 1'b1; fetch_instr = mk(8'h00, 5'd6, 5'd5, 5'd0); #1;
    vecs++;
    if (decode_stall !== 1'b1) begin errs++; $display("FAIL ldw_busy5 got %b want 1", decode_stall); end
    fetch_valid = 1'b0;
  endtask

  task automatic test_alu_stall();
    do_reset();
    wb(5'd1, 32'd1);
    issue_one(mk(8'h00, 5'd2, 5'd1, 5'd1), 32'h40);
    stall_alu = 1'b1; fetch_valid = 1'b1; fetch_instr = mk(8'h02, 5'd7, 5'd1, 5'd1); fetch_pc = 32'h44;
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++;
      if (decode_stall !== 1'b1) begin errs++; $display("FAIL alu_stall%0d got %b want 1", i, decode_stall); end
      tick();
      vecs++;
      if ({dec_valid, rdIn, val1, pc_out} !== {1'b1, 5'd2, 32'd1, 32'h40}) begin
        errs++; $display("FAIL alu_hold%0d got v=%b rd=%0d %h pc=%h want 1 2 1 40", i, dec_valid, rdIn, val1, pc_out);
      end
    end
    stall_alu = 1'b0; #1;
    vecs++;
    if (decode_stall !== 1'b0) begin errs++; $display("FAIL alu_release got %b want 0", decode_stall); end
    tick();
    fetch_valid = 1'b0;
    vecs++;
    if ({dec_valid, instr, rdIn, pc_out} !== {1'b1, 8'h02, 5'd7, 32'h44}) begin
      errs++; $display("FAIL alu_next got v=%b op=%h rd=%0d pc=%h want 1 02 7 44", dec_valid, instr, rdIn, pc_out);
    end
  endtask

  task automatic test_flush();
    do_reset();
    issue_one(mk(8'h00, 5'd6, 5'd0, 5'd0), 32'h80);
    flush = 1'b1; stall_alu = 1'b1; fetch_valid = 1'b1; fetch_instr = mk(8'h00, 5'd7, 5'd6, 5'd6); fetch_pc = 32'h84; #1;
    vecs++;
    if (decode_stall !== 1'b1) begin errs++; $display("FAIL flush_stall got %b want 1", decode_stall); end
    tick();
    flush = 1'b0; stall_alu = 1'b0;
    vecs++;
    if (dec_valid !== 1'b0) begin errs++; $display("FAIL flush_kill got %b want 0", dec_valid); end
    #1;
    vecs++;
    if (decode_stall !== 1'b0) begin errs++; $display("FAIL flush_busy6 got %b want 0", decode_stall); end
    tick();
    fetch_valid = 1'b0;
    vecs++;
    if ({dec_valid, rdIn, pc_out} !== {1'b1, 5'd7, 32'h84}) begin
      errs++; $display("FAIL flush_next got v=%b rd=%0d pc=%h want 1 7 84", dec_valid, rdIn, pc_out);
    end
  endtask

  task automatic test_r0();
    do_reset();
    wb(5'd0, 32'hDEAD);
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hBEEF;
    issue_one(mk(8'h00, 5'd1, 5'd0, 5'd0), 32'hC0);
    wb_valid = 1'b0;
    vecs++;
    if ({dec_valid, val1, val2} !== {1'b1, 64'd0}) begin
      errs++; $display("FAIL r0 got v=%b %h %h want 1 0 0", dec_valid, val1, val2);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    issue_one(mk(8'h00, 5'd3, 5'd0, 5'd0), 32'h10);
    fetch_valid = 1'b1; fetch_instr = mk(8'h01, 5'd4, 5'd3, 5'd3); fetch_pc = 32'h14; #1;
    vecs++;
    if (decode_stall !== 1'b1) begin errs++; $display("FAIL mid_pre_stall got %b want 1", decode_stall); end
    reset_c = 1'b0; #1;
    vecs++;
    if ({dec_valid, rdIn, instr, decode_stall} !== '0) begin
      errs++; $display("FAIL mid_reset got v=%b rd=%0d op=%h st=%b want 0 0 0 0", dec_valid, rdIn, instr, decode_stall);
    end
    reset_c = 1'b1;
    tick();
    fetch_valid = 1'b0;
    vecs++;
    if ({dec_valid, rdIn, pc_out} !== {1'b1, 5'd4, 32'h14}) begin
      errs++; $display("FAIL mid_first got v=%b rd=%0d pc=%h want 1 4 14", dec_valid, rdIn, pc_out);
    end
  endtask

  function automatic void cls(input logic [7:0] op, output bit wr, output bit ua, output bit ub, output bit rbv);
    wr  = op inside {8'h00, 8'h01, 8'h02, 8'h10, 8'h11};
    ua  = op inside {8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h13, 8'h30, 8'h31, 8'h32};
    ub  = op inside {8'h00, 8'h01, 8'h02, 8'h12, 8'h13, 8'h30, 8'h32};
    rbv = op inside {8'h00, 8'h01, 8'h02, 8'h32};
  endfunction

  task automatic test_random();
    logic [7:0] ops [14] = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h13, 8'h30, 8'h31, 8'h32, 8'h33, 8'h7F, 8'h20, 8'hFF};
    logic [31:0] m_rf [32];
    bit m_busy [32];
    bit m_dv, hold, wr, ua, ub, rbv, hit_a, hit_b, e_stall, e_issue;
    logic [7:0] m_op, op;
    logic [31:0] m_v1, m_v2, m_sd, m_pc, va, vb;
    logic [4:0] m_rd, rd, ra, rb;
    do_reset();
    for (int i = 0; i < 32; i++) begin m_rf[i] = '0; m_busy[i] = 1'b0; end
    m_dv = 0; hold = 0; m_op = '0; m_v1 = '0; m_v2 = '0; m_sd = '0; m_pc = '0; m_rd = '0;
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        fetch_valid = $urandom_range(0, 4) != 0;
        fetch_instr = {ops[$urandom_range(0, 13)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 9'($urandom)};
        fetch_pc = $urandom;
      end
      stall_alu = $urandom_range(0, 3) == 0;
      flush = $urandom_range(0, 9) == 0;
      wb_valid = $urandom_range(0, 1) != 0;
      wb_rd = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      #1;
      op = fetch_instr[31:24]; rd = fetch_instr[23:19]; ra = fetch_instr[18:14]; rb = fetch_instr[13:9];
      cls(op, wr, ua, ub, rbv);
      hit_a = BYP && wb_valid && wb_rd == ra && ra != 0;
      hit_b = BYP && wb_valid && wb_rd == rb && rb != 0;
      e_stall = (fetch_valid && ((ua && m_busy[ra] && !hit_a) || (ub && m_busy[rb] && !hit_b))) || flush || (stall_alu && m_dv);
      vecs++;
      if (decode_stall !== e_stall) begin errs++; $display("FAIL rnd_stall c=%0d got %b want %b", c, decode_stall, e_stall); end
      e_issue = fetch_valid && !e_stall;
      va = hit_a ? wb_data : m_rf[ra];
      vb = hit_b ? wb_data : m_rf[rb];
      if (wb_valid) m_busy[wb_rd] = 1'b0;
      if (flush && m_dv) m_busy[m_rd] = 1'b0;
      if (e_issue && wr && rd != 0) m_busy[rd] = 1'b1;
      if (flush) m_dv = 0;
      else if (e_issue) begin
        m_dv = 1; m_op = op; m_v1 = va; m_sd = vb; m_pc = fetch_pc;
        m_v2 = rbv ? vb : 32'(signed'(fetch_instr[13:0]));
        m_rd = wr ? rd : 5'd0;
      end else if (!stall_alu) m_dv = 0;
      if (wb_valid && wb_rd != 0) m_rf[wb_rd] = wb_data;
      hold = fetch_valid && e_stall;
      tick();
      vecs++;
      if (dec_valid !== m_dv) begin errs++; $display("FAIL rnd_valid c=%0d got %b want %b", c, dec_valid, m_dv); end
      if (m_dv) begin
        vecs++;
        if ({instr, val1, val2, store_data, rdIn, pc_out} !== {m_op, m_v1, m_v2, m_sd, m_rd, m_pc}) begin
          errs++; $display("FAIL rnd_out c=%0d got %h %h %h %h %0d %h want %h %h %h %h %0d %h",
            c, instr, val1, val2, store_data, rdIn, pc_out, m_op, m_v1, m_v2, m_sd, m_rd, m_pc);
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_raw_hazard();
    test_load_offset();
    test_alu_stall();
    test_flush();
    test_r0();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
